neural_network: RTL and testbench
=================================

# neural_network

Trainable three-layer fixed-point multilayer perceptron (input → hidden1 → hidden2 → output) with ReLU activations.
It performs a pipelined forward pass, a pipelined backward pass with in-place SGD weight updates, and single-weight host read/write.
It is the compute core of the trainable-NN block; it is driven by the host-interface logic, which supplies inputs and output gradients and reads results.

## Interface
Parameters:
- NUM_WIDTH, 32: width of every number; signed two's complement Q8.24.
- FRAC, 24: fractional bits; 1.0 = 1<<24.
- INPUT_SIZE, 8: layer-0 neuron count.
- HIDDEN1_SIZE, 8: layer-1 neuron count.
- HIDDEN2_SIZE, 8: layer-2 neuron count.
- OUTPUT_SIZE, 8: layer-3 neuron count.
- INDEX_WIDTH, 3: width of the weight-select indices.
- LR_SHIFT, 4: learning rate = 2^-LR_SHIFT.

Ports:
- clk, input, 1: clock; all state changes on the rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- fp, input, 1: start a forward pass.
- fp_out, output, 1: one-cycle pulse; a3_pk holds a new result.
- a0_pk, input, INPUT_SIZE*NUM_WIDTH: input vector; element k at bits [k*NUM_WIDTH +: NUM_WIDTH].
- a3_pk, output, OUTPUT_SIZE*NUM_WIDTH: output activations; same packing.
- bp, input, 1: start a backward pass.
- bp_out, output, 1: one-cycle pulse; all weight updates of the pass are done.
- g3_pk, input, OUTPUT_SIZE*NUM_WIDTH: loss gradient at the outputs; same packing.
- wu, input, 1: host write of the selected weight.
- w_layer, input, 2: selects W01 (0), W12 (1) or W23 (2); 3 selects no weight.
- w_i, input, INDEX_WIDTH: source-neuron index.
- w_j, input, INDEX_WIDTH: destination-neuron index.
- w_in, input, NUM_WIDTH: write data.
- w_out, output, NUM_WIDTH: selected weight, combinational.

## Operation
Weights:
- Wab[i][j] is one register per synapse, from neuron i of layer a to neuron j of layer b.
- The weights sit in generate blocks g_syn01_o[i].g_syn01_i[j].i_syn01 (likewise syn12, syn23); each instance exposes register `w`.

Arithmetic:
- Product: (x*y) computed at 2*NUM_WIDTH bits, then arithmetic-shifted right by FRAC and truncated to NUM_WIDTH.
- Sums wrap modulo 2^NUM_WIDTH; there is no saturation.

Forward pass:
- h1_j = ReLU(Σ_i a0_i·W01[i][j]).
- h2_j = ReLU(Σ_i h1_i·W12[i][j]).
- a3_j = ReLU(Σ_i h2_i·W23[i][j]).
- a0, h1 and h2 stay registered after the pass for use by backprop.

Backward pass:
- g3 is captured from g3_pk.
- g2_i = (Σ_j W23[i][j]·g3_j) if h2_i>0, else 0.
- g1_i = (Σ_j W12[i][j]·g2_j) if h1_i>0, else 0.
- Update: Wab[i][j] -= (act_a_i·g_b_j) >>> LR_SHIFT.
- Each gradient is propagated through the pre-update weights, computed on the same edge as that layer's update.
- The ReLU mask on g3 is not applied; g3 is used as given.

Host access:
- w_out = selected weight.
- w_out = 0 when w_layer=3 or an index is out of range for the layer.
- wu writes w_in to the selected weight; invalid selections are ignored.
- wu wins over a same-edge backprop update of that weight.

## Timing
Forward:
- fp sampled high at edge k captures a0.
- h1 registers at k+1, h2 at k+2, a3 at k+3.
- fp_out is high during the cycle after edge k+3.
- a3_pk changes only at that edge.

Backward:
- bp sampled high at edge m captures g3.
- W23 is updated and g2 is registered at m+1.
- W12 is updated and g1 is registered at m+2.
- W01 is updated at m+3.
- bp_out is high during the cycle after edge m+3.

Pipelining and overlap:
- Stages carry valid bits; back-to-back requests pipeline.
- fp and bp may be requested on the same edge; the backward pass uses the activations stored at its stage edges.

Write/read:
- A wu write takes effect at the sampling edge; w_out shows the new value in the next cycle.

Reset:
- rst_n low clears all weights, activations, gradients and valid bits immediately.
- While reset is active: a3_pk=0, fp_out=0, bp_out=0, w_out=0.
- A pass in flight when reset asserts is discarded; it produces no pulse and no weight update.

## Test plan
- Forward: all weights 0x00400000 (0.25), all a0=1.0; pulse fp → fp_out high 3 edges after the fp edge, every a3=0x08000000 (8.0). Hidden values: h1=2.0, h2=4.0.
- Backward: after the forward test, g3[4]=1.0, others 0; pulse bp → bp_out 3 edges later.
  - W23[i][4]=0; W23[i][j≠4] unchanged.
  - W12=0x00380000 everywhere.
  - W01=0x00380000 everywhere.
- Host write: w_layer=0, w_i=1, w_j=2, w_in=0x00F0CCAA, wu=1 for one cycle → w_out=0x00F0CCAA on the next cycle; other weights unchanged. w_layer=3 → w_out=0.
- ReLU: all W01=-0.25 with a0=1.0 → a3=0. A subsequent bp with any g3 leaves W01 and W12 unchanged.
- Reset mid-pass: assert rst_n low one cycle after fp → no fp_out, a3_pk=0, all weights read 0.
- Collision: wu and the m+1 backprop update target the same W23 entry → w_in is retained.

Source files
------------

// File: rtl/neural_network.sv
// Trainable 3-layer Q8.24 MLP core: pipelined forward pass, pipelined backward
// pass with in-place SGD weight updates, and single-weight host access.

module nn_syn #(
  parameter int NUM_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_wr,
  input  logic [NUM_WIDTH-1:0] i_wdata,
  input  logic                 i_upd,
  input  logic [NUM_WIDTH-1:0] i_delta,
  output logic [NUM_WIDTH-1:0] o_w
);
  logic [NUM_WIDTH-1:0] w;

  // Synapse register; a host write overrides a same-edge training update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      w <= '0;
    else if (i_wr)   w <= i_wdata;
    else if (i_upd)  w <= w - i_delta;
    else             w <= w;
  end

  assign o_w = w;
endmodule

module neural_network #(
  parameter int NUM_WIDTH    = 32,
  parameter int FRAC         = 24,
  parameter int INPUT_SIZE   = 8,
  parameter int HIDDEN1_SIZE = 8,
  parameter int HIDDEN2_SIZE = 8,
  parameter int OUTPUT_SIZE  = 8,
  parameter int INDEX_WIDTH  = 3,
  parameter int LR_SHIFT     = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             fp,
  output logic                             fp_out,
  input  logic [INPUT_SIZE*NUM_WIDTH-1:0]  a0_pk,
  output logic [OUTPUT_SIZE*NUM_WIDTH-1:0] a3_pk,
  input  logic                             bp,
  output logic                             bp_out,
  input  logic [OUTPUT_SIZE*NUM_WIDTH-1:0] g3_pk,
  input  logic                             wu,
  input  logic [1:0]                       w_layer,
  input  logic [INDEX_WIDTH-1:0]           w_i,
  input  logic [INDEX_WIDTH-1:0]           w_j,
  input  logic [NUM_WIDTH-1:0]             w_in,
  output logic [NUM_WIDTH-1:0]             w_out
);
  typedef logic signed [NUM_WIDTH-1:0] num_t;

  function automatic num_t fx_mul(input num_t a, input num_t b);
    logic signed [2*NUM_WIDTH-1:0] p;
    p = (2*NUM_WIDTH)'(a) * (2*NUM_WIDTH)'(b);
    return num_t'(p >>> FRAC);
  endfunction

  function automatic num_t fx_relu(input num_t x);
    return (x < num_t'(0)) ? num_t'(0) : x;
  endfunction

  num_t w_w01 [INPUT_SIZE][HIDDEN1_SIZE];
  num_t w_w12 [HIDDEN1_SIZE][HIDDEN2_SIZE];
  num_t w_w23 [HIDDEN2_SIZE][OUTPUT_SIZE];

  num_t r_a0 [INPUT_SIZE];
  num_t r_h1 [HIDDEN1_SIZE];
  num_t r_h2 [HIDDEN2_SIZE];
  num_t r_a3 [OUTPUT_SIZE];
  num_t r_g3 [OUTPUT_SIZE];
  num_t r_g2 [HIDDEN2_SIZE];
  num_t r_g1 [HIDDEN1_SIZE];
  num_t w_h1_nx [HIDDEN1_SIZE];
  num_t w_h2_nx [HIDDEN2_SIZE];
  num_t w_a3_nx [OUTPUT_SIZE];
  num_t w_g2_nx [HIDDEN2_SIZE];
  num_t w_g1_nx [HIDDEN1_SIZE];

  logic r_fv0, r_fv1, r_fv2, r_fp_out;
  logic r_bv0, r_bv1, r_bv2, r_bp_out;

  // Each layer's update strobe is the backward-pass stage valid of that layer
  for (genvar i = 0; i < INPUT_SIZE; i++) begin : g_syn01_o
    for (genvar j = 0; j < HIDDEN1_SIZE; j++) begin : g_syn01_i
      num_t w_delta;
      logic w_wr;
      assign w_delta = fx_mul(r_a0[i], r_g1[j]) >>> LR_SHIFT;
      assign w_wr = wu && (w_layer == 2'd0) && (w_i == INDEX_WIDTH'(i)) && (w_j == INDEX_WIDTH'(j));
      nn_syn #(.NUM_WIDTH(NUM_WIDTH)) i_syn01 (
        .clk(clk), .rst_n(rst_n), .i_wr(w_wr), .i_wdata(w_in),
        .i_upd(r_bv2), .i_delta(w_delta), .o_w(w_w01[i][j])
      );
    end
  end

  for (genvar i = 0; i < HIDDEN1_SIZE; i++) begin : g_syn12_o
    for (genvar j = 0; j < HIDDEN2_SIZE; j++) begin : g_syn12_i
      num_t w_delta;
      logic w_wr;
      assign w_delta = fx_mul(r_h1[i], r_g2[j]) >>> LR_SHIFT;
      assign w_wr = wu && (w_layer == 2'd1) && (w_i == INDEX_WIDTH'(i)) && (w_j == INDEX_WIDTH'(j));
      nn_syn #(.NUM_WIDTH(NUM_WIDTH)) i_syn12 (
        .clk(clk), .rst_n(rst_n), .i_wr(w_wr), .i_wdata(w_in),
        .i_upd(r_bv1), .i_delta(w_delta), .o_w(w_w12[i][j])
      );
    end
  end

  for (genvar i = 0; i < HIDDEN2_SIZE; i++) begin : g_syn23_o
    for (genvar j = 0; j < OUTPUT_SIZE; j++) begin : g_syn23_i
      num_t w_delta;
      logic w_wr;
      assign w_delta = fx_mul(r_h2[i], r_g3[j]) >>> LR_SHIFT;
      assign w_wr = wu && (w_layer == 2'd2) && (w_i == INDEX_WIDTH'(i)) && (w_j == INDEX_WIDTH'(j));
      nn_syn #(.NUM_WIDTH(NUM_WIDTH)) i_syn23 (
        .clk(clk), .rst_n(rst_n), .i_wr(w_wr), .i_wdata(w_in),
        .i_upd(r_bv0), .i_delta(w_delta), .o_w(w_w23[i][j])
      );
    end
  end

  // Forward layer sums followed by ReLU
  always_comb begin
    for (int j = 0; j < HIDDEN1_SIZE; j++) begin
      w_h1_nx[j] = '0;
      for (int i = 0; i < INPUT_SIZE; i++) w_h1_nx[j] = w_h1_nx[j] + fx_mul(r_a0[i], w_w01[i][j]);
      w_h1_nx[j] = fx_relu(w_h1_nx[j]);
    end
    for (int j = 0; j < HIDDEN2_SIZE; j++) begin
      w_h2_nx[j] = '0;
      for (int i = 0; i < HIDDEN1_SIZE; i++) w_h2_nx[j] = w_h2_nx[j] + fx_mul(r_h1[i], w_w12[i][j]);
      w_h2_nx[j] = fx_relu(w_h2_nx[j]);
    end
    for (int j = 0; j < OUTPUT_SIZE; j++) begin
      w_a3_nx[j] = '0;
      for (int i = 0; i < HIDDEN2_SIZE; i++) w_a3_nx[j] = w_a3_nx[j] + fx_mul(r_h2[i], w_w23[i][j]);
      w_a3_nx[j] = fx_relu(w_a3_nx[j]);
    end
  end

  // Backward gradients through the pre-update weights, masked by ReLU derivative
  always_comb begin
    for (int i = 0; i < HIDDEN2_SIZE; i++) begin
      w_g2_nx[i] = '0;
      for (int j = 0; j < OUTPUT_SIZE; j++) w_g2_nx[i] = w_g2_nx[i] + fx_mul(w_w23[i][j], r_g3[j]);
      if (r_h2[i] > num_t'(0)) w_g2_nx[i] = w_g2_nx[i];
      else                     w_g2_nx[i] = '0;
    end
    for (int i = 0; i < HIDDEN1_SIZE; i++) begin
      w_g1_nx[i] = '0;
      for (int j = 0; j < HIDDEN2_SIZE; j++) w_g1_nx[i] = w_g1_nx[i] + fx_mul(w_w12[i][j], r_g2[j]);
      if (r_h1[i] > num_t'(0)) w_g1_nx[i] = w_g1_nx[i];
      else                     w_g1_nx[i] = '0;
    end
  end

  // Forward pipeline; activations hold until the next pass reaches each stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a0 <= '{default: '0};
      r_h1 <= '{default: '0};
      r_h2 <= '{default: '0};
      r_a3 <= '{default: '0};
      r_fv0 <= 1'b0;
      r_fv1 <= 1'b0;
      r_fv2 <= 1'b0;
      r_fp_out <= 1'b0;
    end else begin
      r_fv0 <= fp;
      r_fv1 <= r_fv0;
      r_fv2 <= r_fv1;
      r_fp_out <= r_fv2;
      if (fp) for (int k = 0; k < INPUT_SIZE; k++) r_a0[k] <= a0_pk[k*NUM_WIDTH +: NUM_WIDTH];
      if (r_fv0) r_h1 <= w_h1_nx;
      if (r_fv1) r_h2 <= w_h2_nx;
      if (r_fv2) r_a3 <= w_a3_nx;
    end
  end

  // Backward pipeline: g3 capture, then g2 and g1 alongside their layer updates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_g3 <= '{default: '0};
      r_g2 <= '{default: '0};
      r_g1 <= '{default: '0};
      r_bv0 <= 1'b0;
      r_bv1 <= 1'b0;
      r_bv2 <= 1'b0;
      r_bp_out <= 1'b0;
    end else begin
      r_bv0 <= bp;
      r_bv1 <= r_bv0;
      r_bv2 <= r_bv1;
      r_bp_out <= r_bv2;
      if (bp) for (int k = 0; k < OUTPUT_SIZE; k++) r_g3[k] <= g3_pk[k*NUM_WIDTH +: NUM_WIDTH];
      if (r_bv0) r_g2 <= w_g2_nx;
      if (r_bv1) r_g1 <= w_g1_nx;
    end
  end

  for (genvar k = 0; k < OUTPUT_SIZE; k++) begin : g_a3_pack
    assign a3_pk[k*NUM_WIDTH +: NUM_WIDTH] = r_a3[k];
  end

  assign fp_out = r_fp_out;
  assign bp_out = r_bp_out;

  // Host read mux; unselected or out-of-range selections read as zero
  always_comb begin
    w_out = '0;
    case (w_layer)
      2'd0: if (int'(w_i) < INPUT_SIZE && int'(w_j) < HIDDEN1_SIZE) w_out = w_w01[w_i][w_j];
            else w_out = '0;
      2'd1: if (int'(w_i) < HIDDEN1_SIZE && int'(w_j) < HIDDEN2_SIZE) w_out = w_w12[w_i][w_j];
            else w_out = '0;
      2'd2: if (int'(w_i) < HIDDEN2_SIZE && int'(w_j) < OUTPUT_SIZE) w_out = w_w23[w_i][w_j];
            else w_out = '0;
      default: w_out = '0;
    endcase
  end
endmodule

// File: tb/tb_neural_network.sv
// Scoreboard bench for neural_network: expected pulses/results are queued at
// issue time and a negedge monitor checks them; weights are checked via w_out.

module tb_neural_network;
  localparam int NW = 32;
  localparam int N  = 8;
  localparam logic [NW-1:0] ONE  = 32'h0100_0000;
  localparam logic [NW-1:0] HALF = 32'h0080_0000;
  localparam logic [NW-1:0] QTR  = 32'h0040_0000;
  localparam logic [NW-1:0] NQTR = 32'hFFC0_0000;

  typedef struct {
    int             cyc;
    logic [N*NW-1:0] a3;
  } fp_exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            fp = 1'b0, bp = 1'b0, wu = 1'b0;
  logic            fp_out, bp_out;
  logic [N*NW-1:0] a0_pk = '0, g3_pk = '0, a3_pk;
  logic [1:0]      w_layer = 2'd0;
  logic [2:0]      w_i = 3'd0, w_j = 3'd0;
  logic [NW-1:0]   w_in = '0, w_out;

  int n_chk = 0, n_fail = 0, cyc = 0;
  fp_exp_t q_fp[$];
  int      q_bp[$];
  fp_exp_t e;
  int      eb;

  neural_network dut (
    .clk(clk), .rst_n(rst_n), .fp(fp), .fp_out(fp_out), .a0_pk(a0_pk), .a3_pk(a3_pk),
    .bp(bp), .bp_out(bp_out), .g3_pk(g3_pk), .wu(wu), .w_layer(w_layer),
    .w_i(w_i), .w_j(w_j), .w_in(w_in), .w_out(w_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [N*NW-1:0] fill(input logic [NW-1:0] v);
    logic [N*NW-1:0] r;
    for (int k = 0; k < N; k++) r[k*NW +: NW] = v;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [N*NW-1:0] act, input logic [N*NW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // Monitor: every output pulse must match the head of its scoreboard queue
  always @(negedge clk) begin
    if (fp_out === 1'b1) begin
      n_chk++;
      if (q_fp.size() == 0) begin
        n_fail++;
        $display("FAIL fp_out_unexpected: pulse at cycle %0d, required none", cyc);
      end else begin
        e = q_fp.pop_front();
        if (cyc != e.cyc || a3_pk !== e.a3) begin
          n_fail++;
          $display("FAIL fp_result: cycle %0d a3 %h, required cycle %0d a3 %h", cyc, a3_pk, e.cyc, e.a3);
        end
      end
    end
    if (bp_out === 1'b1) begin
      n_chk++;
      if (q_bp.size() == 0) begin
        n_fail++;
        $display("FAIL bp_out_unexpected: pulse at cycle %0d, required none", cyc);
      end else begin
        eb = q_bp.pop_front();
        if (cyc != eb) begin
          n_fail++;
          $display("FAIL bp_timing: pulse at cycle %0d, required %0d", cyc, eb);
        end
      end
    end
  end

  task automatic wr(input logic [1:0] l, input int i, input int j, input logic [NW-1:0] v);
    @(negedge clk);
    wu = 1'b1; w_layer = l; w_i = 3'(i); w_j = 3'(j); w_in = v;
    @(negedge clk);
    wu = 1'b0;
  endtask

  task automatic set_all(input logic [1:0] l, input logic [NW-1:0] v);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) wr(l, i, j, v);
  endtask

  task automatic rd(input logic [1:0] l, input int i, input int j, input logic [NW-1:0] exp, input string nm);
    w_layer = l; w_i = 3'(i); w_j = 3'(j);
    #1;
    chk($sformatf("%s[%0d][%0d]", nm, i, j), N*NW'(w_out), N*NW'(exp));
  endtask

  task automatic issue_fp(input logic [N*NW-1:0] a0, input logic [N*NW-1:0] exp);
    @(negedge clk);
    a0_pk = a0; fp = 1'b1;
    q_fp.push_back('{cyc + 4, exp});
    @(negedge clk);
    fp = 1'b0;
  endtask

  task automatic issue_bp(input logic [N*NW-1:0] g3);
    @(negedge clk);
    g3_pk = g3; bp = 1'b1;
    q_bp.push_back(cyc + 4);
    @(negedge clk);
    bp = 1'b0;
  endtask

  initial begin
    logic [N*NW-1:0] g;
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("reset_a3", a3_pk, '0);
    chk("reset_fp_out", N*NW'(fp_out), '0);
    chk("reset_bp_out", N*NW'(bp_out), '0);
    chk("reset_w_out", N*NW'(w_out), '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Forward: all weights 0.25, a0=1.0 -> h1=2, h2=4, a3=8
    set_all(2'd0, QTR); set_all(2'd1, QTR); set_all(2'd2, QTR);
    issue_fp(fill(ONE), fill(32'h0800_0000));
    repeat (6) @(negedge clk);

    // Backward with g3[4]=1.0
    g = '0; g[4*NW +: NW] = ONE;
    issue_bp(g);
    repeat (6) @(negedge clk);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        rd(2'd2, i, j, (j == 4) ? 32'h0 : QTR, "bp_w23");
        rd(2'd1, i, j, 32'h0038_0000, "bp_w12");
        rd(2'd0, i, j, 32'h0038_0000, "bp_w01");
      end

    // Host write and unselected read
    wr(2'd0, 1, 2, 32'h00F0_CCAA);
    rd(2'd0, 1, 2, 32'h00F0_CCAA, "hw_target");
    rd(2'd0, 1, 3, 32'h0038_0000, "hw_neighbor");
    rd(2'd0, 2, 1, 32'h0038_0000, "hw_transposed");
    rd(2'd3, 1, 2, 32'h0, "hw_layer3");

    // ReLU blocks everything: a3=0 and a later bp changes nothing
    set_all(2'd0, NQTR);
    issue_fp(fill(ONE), '0);
    repeat (6) @(negedge clk);
    issue_bp(fill(ONE));
    repeat (6) @(negedge clk);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        rd(2'd0, i, j, NQTR, "relu_w01");
        rd(2'd1, i, j, 32'h0038_0000, "relu_w12");
      end
    rd(2'd2, 0, 4, 32'h0, "relu_w23_col4");
    rd(2'd2, 5, 1, QTR, "relu_w23_other");

    // Back-to-back forward passes (a0=1.0 then 0.5), then bp with collision on W23[2][4]
    set_all(2'd0, QTR); set_all(2'd1, QTR); set_all(2'd2, QTR);
    @(negedge clk);
    a0_pk = fill(ONE); fp = 1'b1;
    q_fp.push_back('{cyc + 4, fill(32'h0800_0000)});
    @(negedge clk);
    a0_pk = fill(HALF);
    q_fp.push_back('{cyc + 4, fill(32'h0400_0000)});
    @(negedge clk);
    fp = 1'b0;
    repeat (6) @(negedge clk);
    g = '0; g[4*NW +: NW] = ONE;
    @(negedge clk);
    g3_pk = g; bp = 1'b1;
    q_bp.push_back(cyc + 4);
    @(negedge clk);
    bp = 1'b0;
    wu = 1'b1; w_layer = 2'd2; w_i = 3'd2; w_j = 3'd4; w_in = 32'h1234_5678;
    @(negedge clk);
    wu = 1'b0;
    repeat (5) @(negedge clk);
    rd(2'd2, 2, 4, 32'h1234_5678, "coll_target");
    rd(2'd2, 3, 4, 32'h0020_0000, "coll_updated");
    rd(2'd2, 2, 3, QTR, "coll_other");
    rd(2'd1, 0, 0, 32'h003C_0000, "coll_w12");

    // Reset one cycle after fp: pass is discarded, everything cleared
    @(negedge clk);
    a0_pk = fill(ONE); fp = 1'b1;
    @(negedge clk);
    fp = 1'b0; rst_n = 1'b0;
    #1;
    chk("rst_a3", a3_pk, '0);
    chk("rst_fp_out", N*NW'(fp_out), '0);
    for (int i = 0; i < N; i++) begin
      rd(2'd0, i, 7 - i, 32'h0, "rst_w01");
      rd(2'd1, i, i, 32'h0, "rst_w12");
      rd(2'd2, i, 4, 32'h0, "rst_w23");
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    chk("post_rst_a3", a3_pk, '0);
    chk("fp_queue_drained", N*NW'(q_fp.size()), '0);
    chk("bp_queue_drained", N*NW'(q_bp.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
